// File: rtl/router_pkg.sv
// router_pkg: parity-mode encodings and parity combine helper.
// Shared by the router packet datapath files.
package router_pkg;

  localparam int PAR_XOR = 0;
  localparam int PAR_SUM = 1;

  // Callers zero-extend their operands and truncate the result
  // back to their own width, so SUM ends up modulo 2^width.
  function automatic logic [31:0] par_combine(
    input int          mode,
    input logic [31:0] acc,
    input logic [31:0] din
  );
    if (mode == PAR_SUM) return acc + din;
    return acc ^ din;
  endfunction

endpackage

// File: rtl/router_hold_buf.sv
// router_hold_buf: circular byte buffer for bytes held while the FIFO is full.
// Ports: clock, resetn, i_push/i_pop/i_din in; o_dout (oldest), o_cnt, o_full, o_empty out.
module router_hold_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_din,
  output logic [DATA_W-1:0]        o_dout,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [CW-1:0]     r_cnt;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A full buffer may still take a byte when one leaves the same cycle.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_dout  = r_mem[r_rd];
  assign o_cnt   = r_cnt;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_reg.sv
// router_pkt_reg: router packet register -- header capture, FIFO byte path with hold buffer, parity check.
// Ports: controller strobes + data_in in; dout/dout_valid, parity flags, hold status, err_cnt out.
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int HOLD_DEPTH = 2,
  parameter int PAR_MODE   = PAR_XOR
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          pkt_valid,
  input  logic                          fifo_full,
  input  logic                          rst_int_reg,
  input  logic                          detect_add,
  input  logic                          lfd_state,
  input  logic                          ld_state,
  input  logic                          laf_state,
  input  logic                          full_state,
  input  logic [DATA_W-1:0]             data_in,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  output logic                          parity_done,
  output logic                          low_pkt_valid,
  output logic                          err,
  output logic [$clog2(HOLD_DEPTH):0]   hold_cnt,
  output logic                          hold_full,
  output logic                          hold_ovf,
  output logic [7:0]                    err_cnt
);

  localparam int CW = $clog2(HOLD_DEPTH) + 1;

  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic [DATA_W-1:0] r_header;
  logic [DATA_W-1:0] r_int_par;
  logic [DATA_W-1:0] r_pkt_par;
  logic              r_parity_done;
  logic              r_pd_d;
  logic              r_low_pkt_valid;
  logic              r_err;
  logic              r_hold_ovf;
  logic [7:0]        r_err_cnt;

  logic              w_addr_bad;
  logic              w_det_clr;
  logic              w_hdr_ld;
  logic              w_ld_wr;
  logic              w_laf_pop;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_pd_set;
  logic              w_pd_rise;
  logic              w_err_nxt;
  logic [DATA_W-1:0] w_hb_dout;
  logic [CW-1:0]     w_hb_cnt;
  logic              w_hb_full;
  logic              w_hb_empty;

  // A header with the reserved address is ignored outright.
  assign w_addr_bad = &data_in[ADDR_W-1:0];
  assign w_det_clr  = detect_add & ~(pkt_valid & w_addr_bad);
  assign w_hdr_ld   = detect_add & pkt_valid & ~w_addr_bad;

  assign w_ld_wr    = ld_state & ~fifo_full;
  assign w_laf_pop  = laf_state & ~fifo_full & ~w_hb_empty;
  // While bytes are held, new bytes queue behind them to keep order.
  assign w_push     = ld_state & (fifo_full ? ~w_hb_full : ~w_hb_empty);
  assign w_pop      = (w_ld_wr & ~w_hb_empty) | w_laf_pop;
  assign w_drop     = ld_state & fifo_full & w_hb_full;

  assign w_pd_set   = (w_ld_wr & w_hb_empty & ~pkt_valid)
                    | (w_laf_pop & (w_hb_cnt == CW'(1)) & r_low_pkt_valid);
  assign w_pd_rise  = r_parity_done & ~r_pd_d;

  always_comb begin
    w_err_nxt = r_err;
    if (w_det_clr)      w_err_nxt = 1'b0;
    else if (w_pd_rise) w_err_nxt = (r_pkt_par != r_int_par);
  end

  router_hold_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (HOLD_DEPTH)
  ) u_hold (
    .clock   (clock),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (data_in),
    .o_dout  (w_hb_dout),
    .o_cnt   (w_hb_cnt),
    .o_full  (w_hb_full),
    .o_empty (w_hb_empty)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_dout          <= '0;
      r_dout_valid    <= 1'b0;
      r_header        <= '0;
      r_int_par       <= '0;
      r_pkt_par       <= '0;
      r_parity_done   <= 1'b0;
      r_pd_d          <= 1'b0;
      r_low_pkt_valid <= 1'b0;
      r_err           <= 1'b0;
      r_hold_ovf      <= 1'b0;
      r_err_cnt       <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      if (lfd_state) begin
        r_dout       <= r_header;
        r_dout_valid <= 1'b1;
      end else if (w_ld_wr) begin
        r_dout       <= w_hb_empty ? data_in : w_hb_dout;
        r_dout_valid <= 1'b1;
      end else if (w_laf_pop) begin
        r_dout       <= w_hb_dout;
        r_dout_valid <= 1'b1;
      end

      if (w_hdr_ld) r_header <= data_in;

      // Dropped bytes still count toward the running parity.
      if (w_det_clr)
        r_int_par <= '0;
      else if (lfd_state)
        r_int_par <= DATA_W'(par_combine(PAR_MODE, 32'(r_int_par), 32'(r_header)));
      else if (ld_state & pkt_valid & ~full_state)
        r_int_par <= DATA_W'(par_combine(PAR_MODE, 32'(r_int_par), 32'(data_in)));

      if (w_det_clr)                 r_pkt_par <= '0;
      else if (ld_state & ~pkt_valid) r_pkt_par <= data_in;

      if (rst_int_reg)               r_low_pkt_valid <= 1'b0;
      else if (ld_state & ~pkt_valid) r_low_pkt_valid <= 1'b1;

      if (w_pd_set)       r_parity_done <= 1'b1;
      else if (w_det_clr) r_parity_done <= 1'b0;
      r_pd_d <= r_parity_done;

      r_err <= w_err_nxt;
      if (w_err_nxt & ~r_err & (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;

      if (w_drop)         r_hold_ovf <= 1'b1;
      else if (w_det_clr) r_hold_ovf <= 1'b0;
    end
  end

  assign dout          = r_dout;
  assign dout_valid    = r_dout_valid;
  assign parity_done   = r_parity_done;
  assign low_pkt_valid = r_low_pkt_valid;
  assign err           = r_err;
  assign hold_cnt      = w_hb_cnt;
  assign hold_full     = w_hb_full;
  assign hold_ovf      = r_hold_ovf;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_router_pkt_reg.sv
// tb_router_pkt_reg: directed packets, dout stream scoreboarded by a negedge monitor.
// A second instance runs PAR_MODE=1 on the same stimulus.
module tb_router_pkt_reg;

  localparam int S_IDLE = 0;
  localparam int S_DET  = 1;
  localparam int S_LFD  = 2;
  localparam int S_LD   = 3;
  localparam int S_LAF  = 4;
  localparam int S_RI   = 5;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, rst_int_reg, detect_add;
  logic       lfd_state, ld_state, laf_state, full_state;
  logic [7:0] data_in;

  logic [7:0] dout, err_cnt;
  logic       dout_valid, parity_done, low_pkt_valid, err;
  logic [1:0] hold_cnt;
  logic       hold_full, hold_ovf;

  logic [7:0] dout_1, err_cnt_1;
  logic       dout_valid_1, parity_done_1, low_pkt_valid_1, err_1;
  logic [1:0] hold_cnt_1;
  logic       hold_full_1, hold_ovf_1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q[$];

  always #5 clock = ~clock;

  router_pkt_reg u_dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg),
    .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .data_in(data_in),
    .dout(dout), .dout_valid(dout_valid),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .err(err), .hold_cnt(hold_cnt), .hold_full(hold_full),
    .hold_ovf(hold_ovf), .err_cnt(err_cnt)
  );

  router_pkt_reg #(.PAR_MODE(1)) u_dut_sum (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg),
    .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .data_in(data_in),
    .dout(dout_1), .dout_valid(dout_valid_1),
    .parity_done(parity_done_1), .low_pkt_valid(low_pkt_valid_1),
    .err(err_1), .hold_cnt(hold_cnt_1), .hold_full(hold_full_1),
    .hold_ovf(hold_ovf_1), .err_cnt(err_cnt_1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int st, input logic pv, input logic ff,
                      input logic [7:0] d);
    detect_add  = (st == S_DET);
    lfd_state   = (st == S_LFD);
    ld_state    = (st == S_LD);
    laf_state   = (st == S_LAF);
    rst_int_reg = (st == S_RI);
    pkt_valid   = pv;
    fifo_full   = ff;
    data_in     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] h, input logic [7:0] p0,
                          input logic [7:0] p1, input logic [7:0] par);
    step(S_DET, 1'b1, 1'b0, h);
    q.push_back(h);   step(S_LFD, 1'b1, 1'b0, 8'h00);
    q.push_back(p0);  step(S_LD,  1'b1, 1'b0, p0);
    q.push_back(p1);  step(S_LD,  1'b1, 1'b0, p1);
    q.push_back(par); step(S_LD,  1'b0, 1'b0, par);
  endtask

  always @(negedge clock) begin
    if (resetn && dout_valid) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got dout %0h, required no byte", dout);
      end else begin
        logic [7:0] e;
        e = q.pop_front();
        if (dout !== e) begin
          n_fail++;
          $display("FAIL sb_dout: got %0h, required %0h", dout, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    full_state = 1'b0;
    step(S_IDLE, 1'b0, 1'b0, 8'h00);
    step(S_IDLE, 1'b0, 1'b0, 8'h00);
    chk("rst_dout",  32'(dout), 0);
    chk("rst_dv",    32'(dout_valid), 0);
    chk("rst_pd",    32'(parity_done), 0);
    chk("rst_lpv",   32'(low_pkt_valid), 0);
    chk("rst_err",   32'(err), 0);
    chk("rst_hcnt",  32'(hold_cnt), 0);
    chk("rst_ovf",   32'(hold_ovf), 0);
    chk("rst_ecnt",  32'(err_cnt), 0);
    resetn = 1'b1;

    send_pkt(8'h05, 8'h11, 8'h22, 8'h36);
    chk("good_pd",  32'(parity_done), 1);
    chk("good_lpv", 32'(low_pkt_valid), 1);
    step(S_IDLE, 1'b0, 1'b0, 8'h00);
    chk("good_err", 32'(err), 0);
    step(S_RI, 1'b0, 1'b0, 8'h00);
    chk("ri_lpv",   32'(low_pkt_valid), 0);

    send_pkt(8'h05, 8'h11, 8'h22, 8'h37);
    step(S_IDLE, 1'b0, 1'b0, 8'h00);
    chk("bad_err",  32'(err), 1);
    chk("bad_ecnt", 32'(err_cnt), 1);
    step(S_RI, 1'b0, 1'b0, 8'h00);
    step(S_DET, 1'b1, 1'b0, 8'h07);
    chk("badaddr_err", 32'(err), 1);
    chk("badaddr_pd",  32'(parity_done), 1);
    step(S_DET, 1'b1, 1'b0, 8'h05);
    chk("det_err",  32'(err), 0);
    chk("det_pd",   32'(parity_done), 0);
    chk("det_ecnt", 32'(err_cnt), 1);

    q.push_back(8'h05); step(S_LFD, 1'b1, 1'b0, 8'h00);
    step(S_LD, 1'b1, 1'b1, 8'hA1);
    chk("hold1_cnt", 32'(hold_cnt), 1);
    chk("hold1_dv",  32'(dout_valid), 0);
    step(S_LD, 1'b1, 1'b1, 8'hA2);
    chk("hold2_cnt",  32'(hold_cnt), 2);
    chk("hold2_full", 32'(hold_full), 1);
    chk("hold2_ovf",  32'(hold_ovf), 0);
    step(S_LD, 1'b1, 1'b1, 8'hA3);
    chk("drop_ovf", 32'(hold_ovf), 1);
    chk("drop_cnt", 32'(hold_cnt), 2);
    q.push_back(8'hA1); step(S_LAF, 1'b1, 1'b0, 8'h00);
    chk("pop1_cnt", 32'(hold_cnt), 1);
    q.push_back(8'hA2); step(S_LAF, 1'b1, 1'b0, 8'h00);
    chk("pop2_cnt",  32'(hold_cnt), 0);
    chk("pop2_full", 32'(hold_full), 0);
    chk("pop2_pd",   32'(parity_done), 0);
    step(S_LAF, 1'b1, 1'b0, 8'h00);
    chk("laf_empty_dv", 32'(dout_valid), 0);
    q.push_back(8'hA5); step(S_LD, 1'b0, 1'b0, 8'hA5);
    chk("drop_pd", 32'(parity_done), 1);
    step(S_IDLE, 1'b0, 1'b0, 8'h00);
    chk("drop_err", 32'(err), 0);
    step(S_RI, 1'b0, 1'b0, 8'h00);

    step(S_DET, 1'b1, 1'b0, 8'h05);
    chk("det_ovf", 32'(hold_ovf), 0);
    q.push_back(8'h05); step(S_LFD, 1'b1, 1'b0, 8'h00);
    step(S_LD, 1'b1, 1'b1, 8'hA1);
    q.push_back(8'hA1); step(S_LD, 1'b1, 1'b0, 8'hB2);
    chk("pass_cnt", 32'(hold_cnt), 1);
    chk("pass_dv",  32'(dout_valid), 1);
    q.push_back(8'hB2); step(S_LD, 1'b0, 1'b0, 8'h16);
    chk("pass_pd0", 32'(parity_done), 0);
    q.push_back(8'h16); step(S_LAF, 1'b0, 1'b0, 8'h00);
    chk("laf_cnt", 32'(hold_cnt), 0);
    chk("laf_pd",  32'(parity_done), 1);
    step(S_IDLE, 1'b0, 1'b0, 8'h00);
    chk("laf_err", 32'(err), 0);
    step(S_RI, 1'b0, 1'b0, 8'h00);

    step(S_DET, 1'b1, 1'b0, 8'hFD);
    q.push_back(8'hFD); step(S_LFD, 1'b1, 1'b0, 8'h00);
    q.push_back(8'h04); step(S_LD, 1'b1, 1'b0, 8'h04);
    q.push_back(8'h01); step(S_LD, 1'b0, 1'b0, 8'h01);
    chk("sum_pd", 32'(parity_done_1), 1);
    step(S_IDLE, 1'b0, 1'b0, 8'h00);
    chk("sum_err",  32'(err_1), 0);
    chk("xor_err",  32'(err), 1);
    chk("xor_ecnt", 32'(err_cnt), 2);
    step(S_RI, 1'b0, 1'b0, 8'h00);

    step(S_DET, 1'b1, 1'b0, 8'h05);
    q.push_back(8'h05); step(S_LFD, 1'b1, 1'b0, 8'h00);
    step(S_LD, 1'b1, 1'b1, 8'hA1);
    chk("mid_cnt", 32'(hold_cnt), 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 0);
    chk("arst_dv",   32'(dout_valid), 0);
    chk("arst_hcnt", 32'(hold_cnt), 0);
    chk("arst_ecnt", 32'(err_cnt), 0);
    chk("arst_err",  32'(err), 0);
    chk("arst_lpv",  32'(low_pkt_valid), 0);
    @(posedge clock);
    #1 resetn = 1'b1;
    send_pkt(8'h05, 8'h11, 8'h22, 8'h36);
    chk("post_pd", 32'(parity_done), 1);
    step(S_IDLE, 1'b0, 1'b0, 8'h00);
    chk("post_err",  32'(err), 0);
    chk("post_ecnt", 32'(err_cnt), 0);
    step(S_IDLE, 1'b0, 1'b0, 8'h00);

    chk("sb_left", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_pkt_reg.md
ROUTER_PKT_REG -- requirements
Module: router_pkt_reg

Interface
REQ-001 Parameter DATA_W, default 8, byte width of the packet datapath.
REQ-002 Parameter ADDR_W, default 2, header address field width (header bits ADDR_W-1:0); all-ones address is invalid.
REQ-003 Parameter HOLD_DEPTH, default 2 (power of 2, >=2), number of bytes held while the destination FIFO is full.
REQ-004 Parameter PAR_MODE, default 0, parity function: 0 = bitwise XOR, 1 = sum modulo 2^DATA_W.
REQ-005 clock  input  1  sole clock, rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 pkt_valid, fifo_full, rst_int_reg, detect_add, lfd_state, ld_state, laf_state, full_state  input  1 each  controller state and handshake strobes; the lfd, ld and laf states are mutually exclusive.
REQ-008 data_in  input  DATA_W  incoming packet byte.
REQ-009 dout  output  DATA_W  byte presented to the destination FIFO.
REQ-010 dout_valid  output  1  dout is a new byte this cycle (FIFO write strobe).
REQ-011 parity_done, low_pkt_valid, err  output  1 each  packet-end, parity-byte-seen and parity-mismatch flags.
REQ-012 hold_cnt  output  $clog2(HOLD_DEPTH)+1  occupancy of the hold buffer; hold_full  output  1  hold_cnt==HOLD_DEPTH.
REQ-013 hold_ovf  output  1  a byte was dropped because the hold buffer was full; err_cnt  output  8  saturating mismatch count.

Function
REQ-014 Header capture: when detect_add & pkt_valid & address!=all-ones, header register SHALL load data_in; an invalid address leaves header and all other state unchanged.
REQ-015 lfd_state: dout<=header, dout_valid=1 next cycle.
REQ-016 ld_state & !fifo_full & hold empty: dout<=data_in, dout_valid=1.
REQ-017 ld_state & !fifo_full & hold non-empty: dout<=oldest hold entry, data_in pushed; hold_cnt unchanged; byte order preserved.
REQ-018 ld_state & fifo_full: data_in pushed to hold buffer, dout and dout_valid=0 held; if hold_full, byte dropped and hold_ovf set.
REQ-019 laf_state & !fifo_full & hold non-empty: pop oldest entry to dout, dout_valid=1, hold_cnt-1; laf_state with fifo_full or hold empty: no change.
REQ-020 dout_valid SHALL be 0 in every cycle not covered by REQ-015..REQ-019; dout holds its value.
REQ-021 Internal parity: cleared on detect_add; lfd_state combines header; ld_state & pkt_valid & !full_state combines data_in, using the PAR_MODE function; dropped bytes (REQ-018) are still combined.
REQ-022 Packet parity: cleared on detect_add; ld_state & !pkt_valid loads data_in.
REQ-023 low_pkt_valid: set on ld_state & !pkt_valid; cleared on rst_int_reg (clear wins).
REQ-024 parity_done: set when parity byte is written to dout (REQ-016) or when a pop in laf_state empties the hold buffer while low_pkt_valid=1; cleared on detect_add; set wins on coincidence.
REQ-025 err: on the cycle after parity_done rises, err<=(packet parity!=internal parity); held until detect_add clears it.
REQ-026 err_cnt increments by 1 on each 0->1 transition of err, saturating at 255; cleared only by reset.
REQ-027 hold_ovf sticky until detect_add.

Reset
REQ-028 resetn low SHALL asynchronously clear dout, dout_valid, header, both parity registers, hold buffer pointers/count, parity_done, low_pkt_valid, err, hold_ovf, err_cnt to 0, including mid-packet; hold buffer storage need not be cleared.

Structure
REQ-029 Shared router package SHALL hold PAR_MODE encodings (PAR_XOR=0, PAR_SUM=1) and the parity-combine function.
REQ-030 Hold buffer SHALL be sub-module router_hold_buf (circular, push/pop/count/full/empty).

Verification
REQ-031 Defaults, header 8'h05, payload 8'h11,8'h22, parity 8'h36, fifo_full=0 -> dout 05,11,22,36 with dout_valid, parity_done=1, err=0 one cycle later.
REQ-032 Same packet, parity byte 8'h37 -> err=1, err_cnt=1; next detect_add clears err, err_cnt stays 1.
REQ-033 fifo_full during payloads 8'hA1,8'hA2 then low, laf_state -> hold_cnt 2, hold_full=1, then dout A1, A2 in order, hold_cnt 0.
REQ-034 Third byte 8'hA3 while hold_full -> hold_ovf=1, A3 never on dout, parity still includes A3.
REQ-035 PAR_MODE=1, header 8'hFD, payload 8'h04, parity 8'h01 -> err=0.
REQ-036 resetn low mid-payload with hold_cnt=1 -> all outputs 0 immediately, next header accepted normally.
